// File: rtl/playback_core_if.sv
// Bus request bundle for the playback_core daisy chain: one instance feeds the core,
// a second carries the registered pass-through to the next core.
interface playback_core_if;
    logic [15:0] addr;
    logic [15:0] data;
    logic        rw;
    logic        valid;

    modport master (output addr, data, rw, valid);
    modport slave  (input  addr, data, rw, valid);
endinterface

// File: rtl/playback_core.sv
// Sample playback core: bus-mapped register file and sample buffer, replayed onto larry/curly/moe/shemp.
// Define PLAYBACK_LOOP_EN to enable the LOOP register (continuous wrap-around playback).
//
// state   | meaning
// IDLE    | stopped (after reset or STOP), outputs hold last value
// PLAYING | stepping one buffer entry per clock onto the outputs
// DONE    | final sample played (or START with zero length), outputs hold
module playback_core #(
    parameter int BASE_ADDR = 0,
    parameter int DEPTH     = 1024
) (
    input  logic              clk,
    input  logic              rst,
    playback_core_if.slave    bus_in,
    playback_core_if.master   bus_out,
    output logic              larry,
    output logic              curly,
    output logic              moe,
    output logic [3:0]        shemp,
    output logic              playing
);
    localparam int IW      = $clog2(DEPTH);
    localparam int MAP_END = 4 + DEPTH;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PLAYING = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [15:0]     length_q;
    logic [6:0]      sample_q;
    logic            load_sample;
    logic            loop_on;
    logic [6:0]      mem [DEPTH];

    logic [15:0]     off;
    logic            in_map, wr, rd, is_buf;
    logic [IW-1:0]   buf_idx;
    logic            start_cmd, stop_cmd;
    logic [15:0]     eff_len;
    logic            last;
    logic [15:0]     rd_val;

    assign off     = bus_in.addr - 16'(BASE_ADDR);
    assign in_map  = (bus_in.addr >= 16'(BASE_ADDR)) && ({16'd0, off} < 32'(MAP_END));
    assign wr      = bus_in.valid && bus_in.rw && in_map;
    assign rd      = bus_in.valid && !bus_in.rw && in_map;
    assign is_buf  = off >= 16'd4;
    assign buf_idx = IW'(off - 16'd4);

    assign start_cmd = wr && (off == 16'd0) && (bus_in.data == 16'd1);
    assign stop_cmd  = wr && (off == 16'd0) && (bus_in.data == 16'd2);

    assign eff_len = (length_q > 16'(DEPTH)) ? 16'(DEPTH) : length_q;
    assign last    = (16'(idx_q) == eff_len - 16'd1);

`ifdef PLAYBACK_LOOP_EN
    logic loop_q;
    always_ff @(posedge clk) begin
        if (rst)
            loop_q <= 1'b0;
        else if (wr && off == 16'd3)
            loop_q <= bus_in.data[0];
    end
    assign loop_on = loop_q;
`else
    assign loop_on = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            sample_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            if (load_sample)
                sample_q <= mem[idx_q];
        end
    end

    // START wins over normal stepping so a restart never leaves a gap cycle
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        load_sample = 1'b0;
        if (state_q == PLAYING) begin
            load_sample = 1'b1;
            if (last) begin
                if (loop_on)
                    idx_d = '0;
                else
                    state_d = DONE;
            end else begin
                idx_d = idx_q + IW'(1);
            end
        end
        if (start_cmd) begin
            idx_d   = '0;
            state_d = (eff_len != 16'd0) ? PLAYING : DONE;
        end else if (stop_cmd) begin
            state_d     = IDLE;
            load_sample = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            length_q <= '0;
        else if (wr && off == 16'd2 && state_q != PLAYING)
            length_q <= bus_in.data;
    end

    // Buffer is deliberately not reset; contents survive a mid-playback reset
    always_ff @(posedge clk) begin
        if (wr && is_buf && state_q != PLAYING)
            mem[buf_idx] <= bus_in.data[6:0];
    end

    always_comb begin
        rd_val = '0;
        case (off)
            16'd1:   rd_val = {14'd0, state_q};
            16'd2:   rd_val = length_q;
            16'd3:   rd_val = {15'd0, loop_on};
            default: if (is_buf) rd_val = {9'd0, mem[buf_idx]};
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus_out.addr  <= '0;
            bus_out.data  <= '0;
            bus_out.rw    <= 1'b0;
            bus_out.valid <= 1'b0;
        end else begin
            bus_out.addr  <= bus_in.addr;
            bus_out.data  <= rd ? rd_val : bus_in.data;
            bus_out.rw    <= bus_in.rw;
            bus_out.valid <= bus_in.valid;
        end
    end

    assign larry   = sample_q[0];
    assign curly   = sample_q[1];
    assign moe     = sample_q[2];
    assign shemp   = sample_q[6:3];
    assign playing = (state_q == PLAYING);
endmodule

// File: tb/tb_playback_core.sv
// Randomised scoreboard bench for playback_core: a playlist-based reference model predicts
// bus responses and per-cycle playback outputs; a monitor compares them on the falling edge.
module tb_playback_core;
    localparam logic [15:0] BASE = 16'h0100;
    localparam int          DEP  = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       larry, curly, moe, playing;
    logic [3:0] shemp;

    playback_core_if bus_in ();
    playback_core_if bus_out ();

    playback_core #(.BASE_ADDR(int'(BASE)), .DEPTH(DEP)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus_in  (bus_in),
        .bus_out (bus_out),
        .larry   (larry),
        .curly   (curly),
        .moe     (moe),
        .shemp   (shemp),
        .playing (playing)
    );

    always #5 clk = ~clk;

    typedef struct { logic [15:0] a; logic [15:0] d; logic rw; } bus_exp_t;
    typedef struct { logic [6:0] s; logic p; } play_exp_t;

    bus_exp_t  bus_q[$];
    play_exp_t play_q[$];
    int vectors = 0;
    int miscompares = 0;

    // reference model: what is shown next is simply the head of a playlist
    logic [6:0]  m_mem [DEP];
    logic [15:0] m_len;
    bit          m_loop;
    logic [6:0]  playlist[$];
    int          m_state;
    logic [6:0]  m_out;

    function automatic logic [15:0] model_read(input int o);
        if (o == 1) return 16'(m_state);
        if (o == 2) return m_len;
`ifdef PLAYBACK_LOOP_EN
        if (o == 3) return {15'd0, m_loop};
`endif
        if (o >= 4) return {9'd0, m_mem[o-4]};
        return 16'd0;
    endfunction

    task automatic model_step(input bit r, input logic [15:0] a, input logic [15:0] d,
                              input bit w, input bit v);
        int o, pre, n;
        bit hit, is_start, is_stop;
        if (r) begin
            playlist.delete();
            m_state = 0; m_out = '0; m_len = '0; m_loop = 0;
            play_q.push_back('{s: m_out, p: 1'b0});
            return;
        end
        pre = m_state;
        o   = int'(a) - int'(BASE);
        hit = (o >= 0) && (o < 4 + DEP);
        if (v) bus_q.push_back('{a: a, d: (hit && !w) ? model_read(o) : d, rw: w});
        is_start = v && w && hit && o == 0 && d == 16'd1;
        is_stop  = v && w && hit && o == 0 && d == 16'd2;
        if (pre == 1 && !is_stop) begin
            m_out = playlist.pop_front();
            if (m_loop) playlist.push_back(m_out);
            if (playlist.size() == 0) m_state = 2;
        end
        if (is_start) begin
            n = (int'(m_len) > DEP) ? DEP : int'(m_len);
            playlist.delete();
            for (int i = 0; i < n; i++) playlist.push_back(m_mem[i]);
            m_state = (n > 0) ? 1 : 2;
        end else if (is_stop) begin
            playlist.delete();
            m_state = 0;
        end
        if (v && w && hit && pre != 1) begin
            if (o == 2) m_len = d;
            if (o >= 4) m_mem[o-4] = d[6:0];
        end
`ifdef PLAYBACK_LOOP_EN
        if (v && w && hit && o == 3) m_loop = d[0];
`endif
        play_q.push_back('{s: m_out, p: (m_state == 1)});
    endtask

    task automatic cyc(input bit r, input logic [15:0] a, input logic [15:0] d,
                       input bit w, input bit v);
        rst = r;
        bus_in.addr = a; bus_in.data = d; bus_in.rw = w; bus_in.valid = v;
        @(posedge clk);
        model_step(r, a, d, w, v);
        #1;
    endtask

    task automatic wr_reg(input int o, input logic [15:0] d);
        cyc(0, BASE + 16'(o), d, 1, 1);
    endtask
    task automatic rd_reg(input int o);
        cyc(0, BASE + 16'(o), 16'($urandom), 0, 1);
    endtask
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 16'($urandom), 16'($urandom), 1'($urandom), 0);
    endtask

    initial begin : monitor
        play_exp_t pe;
        bus_exp_t  be;
        @(posedge clk);
        forever begin
            @(negedge clk);
            if (play_q.size() > 0) begin
                pe = play_q.pop_front();
                vectors++;
                if ({shemp, moe, curly, larry} !== pe.s || playing !== pe.p) begin
                    miscompares++;
                    $display("FAIL playback @%0t: got sample=%h playing=%b, want sample=%h playing=%b",
                             $time, {shemp, moe, curly, larry}, playing, pe.s, pe.p);
                end
            end
            if (bus_out.valid === 1'b1) begin
                vectors++;
                if (bus_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL bus_unexpected @%0t: got valid_o=1 addr=%h, want no response",
                             $time, bus_out.addr);
                end else begin
                    be = bus_q.pop_front();
                    if (bus_out.addr !== be.a || bus_out.data !== be.d || bus_out.rw !== be.rw) begin
                        miscompares++;
                        $display("FAIL bus_resp @%0t: got addr=%h data=%h rw=%b, want addr=%h data=%h rw=%b",
                                 $time, bus_out.addr, bus_out.data, bus_out.rw, be.a, be.d, be.rw);
                    end
                end
            end else if (bus_q.size() > 0) begin
                be = bus_q.pop_front();
                vectors++;
                miscompares++;
                $display("FAIL bus_missing @%0t: got valid_o=%b, want response addr=%h data=%h",
                         $time, bus_out.valid, be.a, be.d);
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        int op, o;
        logic [15:0] a;
        m_len = '0; m_loop = 0; m_state = 0; m_out = '0;
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        for (int i = 0; i < DEP; i++) wr_reg(4 + i, 16'($urandom));
        rd_reg(1); rd_reg(2); rd_reg(0);

        // four-sample pattern then DONE
        wr_reg(4, 16'h01); wr_reg(5, 16'h02); wr_reg(6, 16'h7F); wr_reg(7, 16'h08);
        wr_reg(2, 16'd4); rd_reg(2);
        wr_reg(0, 16'd1); idle(7); rd_reg(1);

        // zero length goes straight to DONE
        wr_reg(2, 16'd0); wr_reg(0, 16'd1); rd_reg(1); idle(3);

        // length clamps to buffer depth
        wr_reg(2, 16'(DEP + 5)); wr_reg(0, 16'd1); idle(DEP + 3); rd_reg(1); idle(2);

        // stop mid-play, then buffer writes are accepted again
        wr_reg(2, 16'd4); wr_reg(0, 16'd1); idle(2);
        wr_reg(5, 16'h33); rd_reg(5);
        wr_reg(0, 16'd2); rd_reg(1); idle(2);
        wr_reg(5, 16'h55); rd_reg(5); rd_reg(1);

        // restart during playback
        wr_reg(2, 16'd5); wr_reg(0, 16'd1); idle(2); wr_reg(0, 16'd1); idle(7);

        // loop mode (or its absence), with a reset mid-stream
        wr_reg(3, 16'd1); rd_reg(3);
        wr_reg(2, 16'd3); wr_reg(0, 16'd1); idle(10);
        cyc(1, 0, 0, 0, 0); rd_reg(1); rd_reg(3); rd_reg(2);

        // out-of-map accesses pass straight through
        cyc(0, BASE + 16'(4 + DEP), 16'hBEEF, 0, 1);
        cyc(0, BASE - 16'd1, 16'h1234, 0, 1);
        cyc(0, BASE + 16'(4 + DEP), 16'hCAFE, 1, 0);
        cyc(0, 16'hFFFF, 16'h5A5A, 1, 1);

        for (int k = 0; k < 600; k++) begin
            op = int'($urandom_range(0, 99));
            if (op < 2) cyc(1, 0, 0, 0, 0);
            else if (op < 20) idle(1);
            else if (op < 40) begin
                o = int'($urandom_range(0, 4 + DEP + 3)) - 2;
                cyc(0, 16'(int'(BASE) + o), 16'($urandom), 0, 1);
            end
            else if (op < 55) wr_reg(4 + int'($urandom_range(0, DEP - 1)), 16'($urandom));
            else if (op < 65) wr_reg(2, 16'($urandom_range(0, DEP + 3)));
            else if (op < 78) wr_reg(0, 16'd1);
            else if (op < 85) wr_reg(0, 16'd2);
            else begin
                a = BASE + 16'($urandom_range(0, 4 + DEP + 2));
                if (a == BASE + 16'd3) a = BASE + 16'd1;
                cyc(0, a, 16'($urandom_range(0, 3)), 1, 1);
            end
        end
        idle(3);
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
